// File: rtl/ps2_frame_decoder.sv
// PS/2 frame checker + scan-code-set-2 prefix FSM feeding a small event FIFO.
// Latency 1 from frameValid to evtValid; full FIFO drops new events (sticky overflowFlag).

module ps2_evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign rd_vld = (count != '0);
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_rdy = (count != FULL_CNT) || rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_frame_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frameValid,
  input  logic [7:0] scanCode,
  input  logic       parityCheckBit,
  input  logic [1:0] commInitBits,
  input  logic       evtReady,
  input  logic       clearErr,
  output logic       evtValid,
  output logic [9:0] evtData,
  output logic [7:0] errorCount,
  output logic       overflowFlag,
  output logic       timeoutPulse
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, cnt_nxt;
  logic          frame_ok, is_e0, is_f0;
  logic          push_vld, push_rdy, err_evt, timeout;
  logic [9:0]    push_dat;

  assign frame_ok = !commInitBits[1] && commInitBits[0] && (^{scanCode, parityCheckBit});
  assign is_e0    = (scanCode == 8'hE0);
  assign is_f0    = (scanCode == 8'hF0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = to_cnt;
    push_vld  = 1'b0;
    push_dat  = 10'h000;
    err_evt   = 1'b0;
    timeout   = 1'b0;
    if (frameValid) begin
      cnt_nxt = '0;
      if (!frame_ok) begin
        err_evt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_e0)      state_nxt = EXT;
            else if (is_f0) state_nxt = BRK;
            else begin
              push_vld = 1'b1;
              push_dat = {2'b00, scanCode};
            end
          end
          EXT: begin
            if (is_f0)      state_nxt = EXT_BRK;
            else if (is_e0) state_nxt = EXT;
            else begin
              push_vld  = 1'b1;
              push_dat  = {2'b10, scanCode};
              state_nxt = IDLE;
            end
          end
          BRK: begin
            state_nxt = IDLE;
            if (is_e0 || is_f0) err_evt = 1'b1;
            else begin
              push_vld = 1'b1;
              push_dat = {2'b01, scanCode};
            end
          end
          EXT_BRK: begin
            state_nxt = IDLE;
            if (is_e0 || is_f0) err_evt = 1'b1;
            else begin
              push_vld = 1'b1;
              push_dat = {2'b11, scanCode};
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      // A frame arriving on the expiry cycle takes the branch above instead.
      if (to_cnt == TO_LAST) begin
        timeout   = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = to_cnt + 1'b1;
      end
    end else begin
      cnt_nxt = '0;
    end
  end

  assign timeoutPulse = timeout;

  ps2_evt_fifo #(.W(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (evtValid),
    .rd_rdy (evtReady),
    .rd_dat (evtData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errorCount   <= 8'h00;
      overflowFlag <= 1'b0;
    end else if (clearErr) begin
      errorCount   <= 8'h00;
      overflowFlag <= 1'b0;
    end else begin
      if (err_evt && errorCount != 8'hFF) errorCount <= errorCount + 8'h01;
      if (push_vld && !push_rdy)          overflowFlag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Directed bench for ps2_frame_decoder: table of single frames plus hand sequences
// for saturation, overflow, timeout, clear and mid-sequence reset.
module tb_ps2_frame_decoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       frameValid;
  logic [7:0] scanCode;
  logic       parityCheckBit;
  logic [1:0] commInitBits;
  logic       evtReady;
  logic       clearErr;
  logic       evtValid;
  logic [9:0] evtData;
  logic [7:0] errorCount;
  logic       overflowFlag;
  logic       timeoutPulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_frame_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frameValid     (frameValid),
    .scanCode       (scanCode),
    .parityCheckBit (parityCheckBit),
    .commInitBits   (commInitBits),
    .evtReady       (evtReady),
    .clearErr       (clearErr),
    .evtValid       (evtValid),
    .evtData        (evtData),
    .errorCount     (errorCount),
    .overflowFlag   (overflowFlag),
    .timeoutPulse   (timeoutPulse)
  );

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       start;
    logic       stop;
    logic       exp_vld;
    logic [9:0] exp_dat;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic logic gp(input logic [7:0] c);
    return ~^c;
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic bp, input logic s, input logic t,
                              input logic v, input logic [9:0] d, input logic [7:0] e);
    vec_t r;
    r.code = c; r.bad_par = bp; r.start = s; r.stop = t;
    r.exp_vld = v; r.exp_dat = d; r.exp_err = e;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic p, input logic s, input logic t);
    @(negedge clk);
    scanCode = c; parityCheckBit = p; commInitBits = {s, t}; frameValid = 1'b1;
    @(negedge clk);
    frameValid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    evtReady = 1'b1;
    @(negedge clk);
    evtReady = 1'b0;
  endtask

  initial begin
    int first_pulse;
    int n_pulse;
    logic [9:0] exp_q[4];

    rst_n = 1'b0; frameValid = 1'b0; scanCode = 8'h00; parityCheckBit = 1'b0;
    commInitBits = 2'b01; evtReady = 1'b0; clearErr = 1'b0;

    //            code   bp start stop vld dat     err
    vt.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h01C, 0));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 0));
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
    vt.push_back(mk(8'h75, 0, 0, 1, 1, 10'h375, 0));
    vt.push_back(mk(8'h1C, 1, 0, 1, 0, 10'h000, 1));
    vt.push_back(mk(8'h1C, 0, 0, 0, 0, 10'h000, 2));
    vt.push_back(mk(8'h1C, 0, 1, 1, 0, 10'h000, 3));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 3));
    vt.push_back(mk(8'h74, 0, 0, 1, 1, 10'h274, 3));
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 3));
    vt.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h11C, 3));
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 3));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 4));
    vt.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h01C, 4));
    vt.push_back(mk(8'hAA, 0, 0, 1, 1, 10'h0AA, 4));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 4));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 4));
    vt.push_back(mk(8'h12, 0, 0, 1, 1, 10'h212, 4));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 4));
    vt.push_back(mk(8'h12, 1, 0, 1, 0, 10'h000, 5));
    vt.push_back(mk(8'h12, 0, 0, 1, 1, 10'h012, 5));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 5));
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 5));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 6));
    vt.push_back(mk(8'h75, 0, 0, 1, 1, 10'h075, 6));

    repeat (3) @(negedge clk);
    chk("rst_evtValid", evtValid, 0);
    chk("rst_evtData", evtData, 0);
    chk("rst_errorCount", errorCount, 0);
    chk("rst_overflow", overflowFlag, 0);
    chk("rst_timeout", timeoutPulse, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].code, gp(vt[i].code) ^ vt[i].bad_par, vt[i].start, vt[i].stop);
      chk($sformatf("vec%0d_vld", i), evtValid, vt[i].exp_vld);
      if (vt[i].exp_vld) begin
        chk($sformatf("vec%0d_dat", i), evtData, vt[i].exp_dat);
        pop();
        chk($sformatf("vec%0d_popped", i), evtValid, 0);
      end
      chk($sformatf("vec%0d_err", i), errorCount, vt[i].exp_err);
    end

    // Saturation and clear
    for (int i = 0; i < 300; i++) send(8'h1C, 1'b1, 1'b0, 1'b1);
    chk("err_saturate", errorCount, 255);
    @(negedge clk); clearErr = 1'b1;
    @(negedge clk); clearErr = 1'b0;
    chk("err_cleared", errorCount, 0);
    send(8'h1C, 1'b1, 1'b0, 1'b1);
    chk("err_after_clear", errorCount, 1);
    @(negedge clk);
    scanCode = 8'h1C; parityCheckBit = 1'b1; commInitBits = 2'b01; frameValid = 1'b1; clearErr = 1'b1;
    @(negedge clk);
    frameValid = 1'b0; clearErr = 1'b0;
    chk("clear_beats_err", errorCount, 0);

    // Ready while empty is ignored
    @(negedge clk); evtReady = 1'b1;
    @(negedge clk); evtReady = 1'b0;
    chk("empty_pop_vld", evtValid, 0);

    // Overflow with depth 4
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), gp(8'h11 + 8'(i)), 1'b0, 1'b1);
    chk("ovf_vld", evtValid, 1);
    chk("ovf_head", evtData, 10'h011);
    chk("ovf_flag", overflowFlag, 1);
    @(negedge clk);
    scanCode = 8'h16; parityCheckBit = gp(8'h16); commInitBits = 2'b01; frameValid = 1'b1; evtReady = 1'b1;
    @(negedge clk);
    frameValid = 1'b0; evtReady = 1'b0;
    exp_q[0] = 10'h012; exp_q[1] = 10'h013; exp_q[2] = 10'h014; exp_q[3] = 10'h016;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_drain%0d_vld", i), evtValid, 1);
      chk($sformatf("full_drain%0d_dat", i), evtData, exp_q[i]);
      pop();
    end
    chk("full_drain_empty", evtValid, 0);
    chk("ovf_sticky", overflowFlag, 1);
    @(negedge clk); clearErr = 1'b1;
    @(negedge clk); clearErr = 1'b0;
    chk("ovf_cleared", overflowFlag, 0);

    // Timeout after a lone E0
    send(8'hE0, gp(8'hE0), 1'b0, 1'b1);
    chk("to_cycle0", timeoutPulse, 0);
    first_pulse = -1; n_pulse = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (timeoutPulse) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    chk("to_first_cycle", first_pulse, 9);
    chk("to_pulse_count", n_pulse, 1);
    chk("to_no_err", errorCount, 0);
    send(8'h1C, gp(8'h1C), 1'b0, 1'b1);
    chk("to_next_dat", evtData, 10'h01C);
    pop();

    // Frame arriving on the expiry cycle wins
    send(8'hE0, gp(8'hE0), 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    scanCode = 8'h74; parityCheckBit = gp(8'h74); commInitBits = 2'b01; frameValid = 1'b1;
    #1;
    chk("to_frame_wins_pulse", timeoutPulse, 0);
    @(negedge clk);
    frameValid = 1'b0;
    chk("to_frame_wins_dat", evtData, 10'h274);
    pop();
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (timeoutPulse) n_pulse++;
    end
    chk("to_none_after_win", n_pulse, 0);

    // Reset mid-sequence
    send(8'h22, gp(8'h22), 1'b0, 1'b1);
    send(8'hF0, gp(8'hF0), 1'b0, 1'b1);
    send(8'h1C, 1'b1, 1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_vld", evtValid, 0);
    chk("midrst_err", errorCount, 0);
    rst_n = 1'b1;
    send(8'hF0, gp(8'hF0), 1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send(8'h1C, gp(8'h1C), 1'b0, 1'b1);
    chk("midrst_next_vld", evtValid, 1);
    chk("midrst_next_dat", evtData, 10'h01C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
